lfsr_period_engine: RTL

Parametrised LFSR generator with a built-in period checker. It is the successor to the fixed 8-bit `lfsr` and brings the maximal-length proof that the current bench performs into hardware. It supports Fibonacci and Galois modes with a polynomial set by parameter. It measures the cycle length from the loaded seed, flags maximal sequences and detects the all-zero lock-up state. It sits beside the pattern sources and its status can be read back by the lab controller.

---
 rtl/lfsr_period_engine_pkg.sv | 51 +++++
 rtl/lfsr_period_engine_step.sv | 22 ++
 rtl/lfsr_period_engine.sv | 94 +++++++++
 3 files changed

// File: rtl/lfsr_period_engine_pkg.sv
// lfsr_pkg: shared state encoding, tap conversion and default polynomial table
package lfsr_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE, LOCKUP} state_e;

    localparam int MIN_WIDTH = 3;
    localparam int MAX_WIDTH = 32;

    // Fibonacci tap mask from a Galois-style coefficient set: x^W becomes the top tap
    function automatic logic [31:0] fib_taps(input logic [31:0] poly, input int w);
        return (poly >> 1) | (32'd1 << (w - 1));
    endfunction

    // Primitive polynomials, coefficients x^(w-1)..x^0 with x^w implicit
    function automatic logic [31:0] default_poly(input int w);
        case (w)
            3:       return 32'h0000_0005;
            4:       return 32'h0000_0009;
            5:       return 32'h0000_0009;
            6:       return 32'h0000_0021;
            7:       return 32'h0000_0041;
            8:       return 32'h0000_0071;
            9:       return 32'h0000_0021;
            10:      return 32'h0000_0081;
            11:      return 32'h0000_0201;
            12:      return 32'h0000_0C11;
            13:      return 32'h0000_1901;
            14:      return 32'h0000_3005;
            15:      return 32'h0000_4001;
            16:      return 32'h0000_A011;
            17:      return 32'h0000_4001;
            18:      return 32'h0000_0801;
            19:      return 32'h0006_4001;
            20:      return 32'h0002_0001;
            21:      return 32'h0008_0001;
            22:      return 32'h0020_0001;
            23:      return 32'h0004_0001;
            24:      return 32'h00C2_0001;
            25:      return 32'h0040_0001;
            26:      return 32'h0000_0047;
            27:      return 32'h0000_0027;
            28:      return 32'h0200_0001;
            29:      return 32'h0800_0001;
            30:      return 32'h0000_0053;
            31:      return 32'h1000_0001;
            32:      return 32'h0040_0007;
            default: return 32'h0000_0001;
        endcase
    endfunction

endpackage

// File: rtl/lfsr_period_engine_step.sv
// lfsr_step: combinational one-step LFSR advance in Fibonacci or Galois form
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int                WIDTH = 8,
    parameter logic [WIDTH-1:0]  POLY  = WIDTH'(default_poly(WIDTH))
) (
    input  logic [WIDTH-1:0] r_i,
    input  logic             mode_i,
    output logic [WIDTH-1:0] r_o
);

    localparam logic [WIDTH-1:0] TAPF = WIDTH'(fib_taps(32'(POLY), WIDTH));

    logic [WIDTH-1:0] fib;
    logic [WIDTH-1:0] gal;

    assign fib = {r_i[WIDTH-2:0], ^(r_i & TAPF)};
    assign gal = {r_i[WIDTH-2:0], 1'b0} ^ (r_i[WIDTH-1] ? POLY : '0);
    assign r_o = mode_i ? gal : fib;

endmodule

// File: rtl/lfsr_period_engine.sv
// lfsr_period_engine: LFSR generator that measures the cycle length from the loaded seed
module lfsr_period_engine
    import lfsr_pkg::*;
#(
    parameter int                WIDTH = 8,
    parameter logic [WIDTH-1:0]  POLY  = WIDTH'(default_poly(WIDTH))
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] seed,
    input  logic             load,
    input  logic             en,
    input  logic             mode,
    output logic [WIDTH-1:0] lfsr_out,
    output logic [WIDTH:0]   period,
    output logic             busy,
    output logic             done,
    output logic             maximal,
    output logic             lockup
);

    localparam logic [WIDTH:0] CNT_FULL   = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH:0] MAX_PERIOD = {1'b0, {WIDTH{1'b1}}};

    state_e           state_q;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] seed_q;
    logic             mode_q;
    logic [WIDTH:0]   cnt_q;
    logic [WIDTH:0]   cnt_d;
    logic [WIDTH:0]   period_q;
    logic             busy_q;
    logic             done_q;

    lfsr_step #(.WIDTH(WIDTH), .POLY(POLY)) u_step (
        .r_i    (r_q),
        .mode_i (mode_q),
        .r_o    (r_d)
    );

    assign cnt_d = cnt_q + (WIDTH+1)'(1);

    // Load/measure/free-run controller; counting stops at the return to seed or at 2^WIDTH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            r_q      <= '0;
            seed_q   <= '0;
            mode_q   <= 1'b0;
            cnt_q    <= '0;
            period_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (load) begin
            state_q  <= (seed == '0) ? LOCKUP : RUN;
            r_q      <= seed;
            seed_q   <= seed;
            mode_q   <= mode;
            cnt_q    <= '0;
            period_q <= '0;
            busy_q   <= (seed != '0);
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                RUN: if (en) begin
                    r_q   <= r_d;
                    cnt_q <= cnt_d;
                    if (r_d == seed_q) begin
                        state_q  <= DONE;
                        period_q <= cnt_d;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end else if (cnt_d == CNT_FULL) begin
                        state_q  <= DONE;
                        period_q <= '0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end
                end
                DONE: if (en) r_q <= r_d;
                default: ;
            endcase
        end
    end

    assign lfsr_out = r_q;
    assign period   = period_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign maximal  = done_q && (period_q == MAX_PERIOD);
    assign lockup   = (r_q == '0);

endmodule
